// File: rtl/branch_predictor_param_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : branch_predictor_param_if                                   |
// | Description : Bundle between the IF/ID pipeline stages and the branch     |
// |               predictor. The lookup path carries the IF-stage PC and the  |
// |               prediction. The update path carries the ID-stage branch     |
// |               resolution. The bundle also carries bulk invalidate and the |
// |               statistics counters.                                        |
// | Modports    : master - pipeline side (drives lookup/update requests)      |
// |               slave  - predictor side (returns prediction and stats)      |
// | Revision    : 1.0 - initial release                                       |
// +--------------------------------------------------------------------------+
interface branch_predictor_param_if #(
  parameter int WORD = 16
);
  logic [WORD-1:0] curPC;
  logic            predTaken;
  logic [WORD-1:0] predPC;
  logic            upd_en;
  logic [WORD-1:0] upd_pc;
  logic            upd_taken;
  logic [WORD-1:0] upd_target;
  logic            upd_mispred;
  logic            inv_all;
  logic [WORD-1:0] update_cnt;
  logic [WORD-1:0] mispred_cnt;

  modport master (
    output curPC, upd_en, upd_pc, upd_taken, upd_target, upd_mispred, inv_all,
    input  predTaken, predPC, update_cnt, mispred_cnt
  );

  modport slave (
    input  curPC, upd_en, upd_pc, upd_taken, upd_target, upd_mispred, inv_all,
    output predTaken, predPC, update_cnt, mispred_cnt
  );
endinterface
`default_nettype wire

// File: rtl/branch_predictor_param.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : branch_predictor_param                                      |
// | Description : Direct-mapped branch target buffer. Each entry holds a      |
// |               valid bit, a tag, a target and an N-bit saturating          |
// |               direction counter. Lookup is combinational. Update comes    |
// |               from ID-stage resolution and is registered. The block also  |
// |               provides bulk invalidate and saturating update/mispredict   |
// |               statistics.                                                 |
// | Ports       : Clk      - clock                                            |
// |               Reset_N  - synchronous active-low reset                     |
// |               bp       - slave side of branch_predictor_param_if          |
// |                 curPC/predTaken/predPC        : IF-stage lookup           |
// |                 upd_en/upd_pc/upd_taken/                                  |
// |                 upd_target/upd_mispred        : ID-stage resolution       |
// |                 inv_all                       : clear all valid bits      |
// |                 update_cnt/mispred_cnt        : statistics                |
// | Revision    : 1.0 - initial release                                       |
// +--------------------------------------------------------------------------+
module branch_predictor_param #(
  parameter int WORD     = 16,
  parameter int IDX_BITS = 4,
  parameter int CNT_BITS = 2,
  parameter int MODE     = 1
) (
  input  wire logic              Clk,
  input  wire logic              Reset_N,
  branch_predictor_param_if.slave bp
);

  localparam int c_depth = 1 << IDX_BITS;
  localparam int c_tag_w = WORD - IDX_BITS;

  // Counter encodings: saturate high, weakly not-taken (reset), weakly taken (alloc)
  localparam logic [CNT_BITS-1:0] c_cnt_max = {CNT_BITS{1'b1}};
  localparam logic [CNT_BITS-1:0] c_cnt_wnt = CNT_BITS'((2 ** (CNT_BITS - 1)) - 1);
  localparam logic [CNT_BITS-1:0] c_cnt_wt  = CNT_BITS'(2 ** (CNT_BITS - 1));
  localparam logic [WORD-1:0]     c_stat_max = {WORD{1'b1}};

  // Table state
  logic [c_depth-1:0]  valid_q, valid_d;
  logic [c_tag_w-1:0]  tag_q [c_depth];
  logic [c_tag_w-1:0]  tag_d [c_depth];
  logic [WORD-1:0]     tgt_q [c_depth];
  logic [WORD-1:0]     tgt_d [c_depth];
  logic [CNT_BITS-1:0] cnt_q [c_depth];
  logic [CNT_BITS-1:0] cnt_d [c_depth];

  // Statistics
  logic [WORD-1:0] update_cnt_q, update_cnt_d;
  logic [WORD-1:0] mispred_cnt_q, mispred_cnt_d;

  // Lookup
  logic [IDX_BITS-1:0] w_idx;
  logic [c_tag_w-1:0]  w_tag;
  logic                w_hit;
  logic                w_pred_taken;

  // Update
  logic [IDX_BITS-1:0] w_uidx;
  logic [c_tag_w-1:0]  w_utag;
  logic                w_uhit;
  logic                w_upd_go;

  // ---------------------------------------------------------------------
  // Lookup. This path reads only the registered table, so an update in
  // the same cycle is seen from the next cycle and is never bypassed.
  // ---------------------------------------------------------------------
  always_comb begin
    w_idx = bp.curPC[IDX_BITS-1:0];
    w_tag = bp.curPC[WORD-1:IDX_BITS];
    w_hit = valid_q[w_idx] && (tag_q[w_idx] == w_tag);
    if (MODE == 0) begin
      w_pred_taken = w_hit;
    end else begin
      w_pred_taken = w_hit && cnt_q[w_idx][CNT_BITS-1];
    end
  end

  always_comb begin
    bp.predTaken   = w_pred_taken;
    // The fall-through PC wraps naturally at the WORD width
    bp.predPC      = w_pred_taken ? tgt_q[w_idx] : bp.curPC + WORD'(1);
    bp.update_cnt  = update_cnt_q;
    bp.mispred_cnt = mispred_cnt_q;
  end

  // ---------------------------------------------------------------------
  // Next-state computation
  // ---------------------------------------------------------------------
  always_comb begin
    w_uidx   = bp.upd_pc[IDX_BITS-1:0];
    w_utag   = bp.upd_pc[WORD-1:IDX_BITS];
    w_uhit   = valid_q[w_uidx] && (tag_q[w_uidx] == w_utag);
    // inv_all drops a coincident update entirely, statistics included
    w_upd_go = bp.upd_en && !bp.inv_all;

    valid_d       = valid_q;
    tag_d         = tag_q;
    tgt_d         = tgt_q;
    cnt_d         = cnt_q;
    update_cnt_d  = update_cnt_q;
    mispred_cnt_d = mispred_cnt_q;

    if (bp.inv_all) begin
      // Only the valid bits are cleared. Tags, targets and counters stay stale.
      valid_d = '0;
    end else if (bp.upd_en) begin
      if (w_uhit) begin
        if (bp.upd_taken) begin
          tgt_d[w_uidx] = bp.upd_target;
          if (cnt_q[w_uidx] != c_cnt_max) begin
            cnt_d[w_uidx] = cnt_q[w_uidx] + CNT_BITS'(1);
          end
        end else if (cnt_q[w_uidx] != '0) begin
          cnt_d[w_uidx] = cnt_q[w_uidx] - CNT_BITS'(1);
        end
      end else if (bp.upd_taken) begin
        // Allocate on a taken miss. A not-taken miss is not worth storing.
        valid_d[w_uidx] = 1'b1;
        tag_d[w_uidx]   = w_utag;
        tgt_d[w_uidx]   = bp.upd_target;
        cnt_d[w_uidx]   = c_cnt_wt;
      end
    end

    if (w_upd_go) begin
      if (update_cnt_q != c_stat_max) begin
        update_cnt_d = update_cnt_q + WORD'(1);
      end
      if (bp.upd_mispred && (mispred_cnt_q != c_stat_max)) begin
        mispred_cnt_d = mispred_cnt_q + WORD'(1);
      end
    end
  end

  // ---------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------
  always_ff @(posedge Clk) begin
    if (!Reset_N) begin
      valid_q       <= '0;
      update_cnt_q  <= '0;
      mispred_cnt_q <= '0;
      for (int i = 0; i < c_depth; i++) begin
        tag_q[i] <= '0;
        tgt_q[i] <= '0;
        cnt_q[i] <= c_cnt_wnt;
      end
    end else begin
      valid_q       <= valid_d;
      tag_q         <= tag_d;
      tgt_q         <= tgt_d;
      cnt_q         <= cnt_d;
      update_cnt_q  <= update_cnt_d;
      mispred_cnt_q <= mispred_cnt_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_branch_predictor_param.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_branch_predictor_param                                   |
// | Description : Scoreboard bench for three predictor instances:            |
// |               A (WORD16, MODE1), B (WORD16, MODE0 legacy),               |
// |               C (WORD4, IDX_BITS2, MODE1). All three get the same        |
// |               stimulus, with C seeing only the low 4 bits. Expected      |
// |               outputs come from an arithmetic reference model and are    |
// |               queued. A negedge monitor pops and compares them.          |
// | Revision    : 1.0 - initial release                                       |
// +--------------------------------------------------------------------------+
module tb_branch_predictor_param;

  logic Clk = 1'b0;
  logic Reset_N;
  always #5 Clk = ~Clk;

  branch_predictor_param_if #(.WORD(16)) bp_a ();
  branch_predictor_param_if #(.WORD(16)) bp_b ();
  branch_predictor_param_if #(.WORD(4))  bp_c ();

  branch_predictor_param #(.WORD(16), .IDX_BITS(4), .CNT_BITS(2), .MODE(1)) u_a (
    .Clk(Clk), .Reset_N(Reset_N), .bp(bp_a.slave));
  branch_predictor_param #(.WORD(16), .IDX_BITS(4), .CNT_BITS(2), .MODE(0)) u_b (
    .Clk(Clk), .Reset_N(Reset_N), .bp(bp_b.slave));
  branch_predictor_param #(.WORD(4),  .IDX_BITS(2), .CNT_BITS(2), .MODE(1)) u_c (
    .Clk(Clk), .Reset_N(Reset_N), .bp(bp_c.slave));

  // ---------------- reference model ----------------
  int p_word [3] = '{16, 16, 4};
  int p_idx  [3] = '{4, 4, 2};
  int p_mode [3] = '{1, 0, 1};
  localparam int c_cmax = 3;  // 2**CNT_BITS-1 with CNT_BITS=2

  bit m_valid [3][16];
  int m_tag   [3][16];
  int m_tgt   [3][16];
  int m_cnt   [3][16];
  int m_uc    [3];
  int m_mc    [3];

  // Inputs currently presented to the DUTs (the model consumes them at posedge)
  bit s_rst_n, s_en, s_tk, s_mis, s_inv;
  int s_cur, s_pc, s_tgt;

  typedef struct {
    int inst;
    bit taken;
    int pc;
    int uc;
    int mc;
  } exp_t;
  exp_t sb_q[$];

  int total = 0;
  int bad   = 0;

  function automatic int msk(int i, int v);
    return v % (1 << p_word[i]);
  endfunction

  task automatic model_step(int i);
    int pc, idx, tag;
    if (!s_rst_n) begin
      for (int k = 0; k < 16; k++) begin
        m_valid[i][k] = 0; m_tag[i][k] = 0; m_tgt[i][k] = 0; m_cnt[i][k] = 1;
      end
      m_uc[i] = 0; m_mc[i] = 0;
      return;
    end
    if (s_inv) begin
      for (int k = 0; k < 16; k++) m_valid[i][k] = 0;
      return;
    end
    if (!s_en) return;
    pc  = msk(i, s_pc);
    idx = pc % (1 << p_idx[i]);
    tag = pc / (1 << p_idx[i]);
    if (m_valid[i][idx] && m_tag[i][idx] == tag) begin
      if (s_tk) begin
        m_tgt[i][idx] = msk(i, s_tgt);
        if (m_cnt[i][idx] < c_cmax) m_cnt[i][idx]++;
      end else if (m_cnt[i][idx] > 0) begin
        m_cnt[i][idx]--;
      end
    end else if (s_tk) begin
      m_valid[i][idx] = 1; m_tag[i][idx] = tag;
      m_tgt[i][idx] = msk(i, s_tgt); m_cnt[i][idx] = 2;
    end
    if (m_uc[i] < (1 << p_word[i]) - 1) m_uc[i]++;
    if (s_mis && m_mc[i] < (1 << p_word[i]) - 1) m_mc[i]++;
  endtask

  task automatic push_expect(int i);
    exp_t e;
    int cur, idx, tag;
    bit hit;
    cur = msk(i, s_cur);
    idx = cur % (1 << p_idx[i]);
    tag = cur / (1 << p_idx[i]);
    hit = m_valid[i][idx] && (m_tag[i][idx] == tag);
    e.inst  = i;
    e.taken = hit && (p_mode[i] == 0 || m_cnt[i][idx] >= 2);
    e.pc    = e.taken ? m_tgt[i][idx] : msk(i, cur + 1);
    e.uc    = m_uc[i];
    e.mc    = m_mc[i];
    sb_q.push_back(e);
  endtask

  task automatic drive_ifs();
    Reset_N          = s_rst_n;
    bp_a.curPC       = s_cur[15:0];   bp_b.curPC       = s_cur[15:0];   bp_c.curPC       = s_cur[3:0];
    bp_a.upd_en      = s_en;          bp_b.upd_en      = s_en;          bp_c.upd_en      = s_en;
    bp_a.upd_pc      = s_pc[15:0];    bp_b.upd_pc      = s_pc[15:0];    bp_c.upd_pc      = s_pc[3:0];
    bp_a.upd_taken   = s_tk;          bp_b.upd_taken   = s_tk;          bp_c.upd_taken   = s_tk;
    bp_a.upd_target  = s_tgt[15:0];   bp_b.upd_target  = s_tgt[15:0];   bp_c.upd_target  = s_tgt[3:0];
    bp_a.upd_mispred = s_mis;         bp_b.upd_mispred = s_mis;         bp_c.upd_mispred = s_mis;
    bp_a.inv_all     = s_inv;         bp_b.inv_all     = s_inv;         bp_c.inv_all     = s_inv;
  endtask

  // One clock: the model absorbs the inputs that were live at this posedge,
  // then new inputs are applied and their expected response is queued.
  task automatic cyc(bit rn, int cur, bit en, int pc, bit tk, int tgt, bit mis, bit inv);
    @(posedge Clk);
    for (int i = 0; i < 3; i++) model_step(i);
    #1;
    s_rst_n = rn; s_cur = cur; s_en = en; s_pc = pc; s_tk = tk;
    s_tgt = tgt; s_mis = mis; s_inv = inv;
    drive_ifs();
    for (int i = 0; i < 3; i++) push_expect(i);
  endtask

  // Lookup-only cycle
  task automatic look(int cur);
    cyc(1, cur, 0, 0, 0, 0, 0, 0);
  endtask

  // Update cycle, with a lookup riding along
  task automatic upd(int cur, int pc, bit tk, int tgt, bit mis);
    cyc(1, cur, 1, pc, tk, tgt, mis, 0);
  endtask

  function automatic int rnd_pc();
    if ($urandom_range(0, 9) == 0) return int'($urandom_range(0, 16'hFFFF));
    return ($urandom_range(0, 2) << 4) | $urandom_range(0, 15);
  endfunction

  // ---------------- monitor ----------------
  task automatic check(string name, int inst, int got, int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s inst=%0d got=%0h exp=%0h t=%0t", name, inst, got, exp, $time);
    end
  endtask

  initial begin
    exp_t e;
    int g_tk, g_pc, g_uc, g_mc;
    forever begin
      @(negedge Clk);
      while (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        case (e.inst)
          0: begin
            g_tk = int'(bp_a.predTaken); g_pc = int'(bp_a.predPC);
            g_uc = int'(bp_a.update_cnt); g_mc = int'(bp_a.mispred_cnt);
          end
          1: begin
            g_tk = int'(bp_b.predTaken); g_pc = int'(bp_b.predPC);
            g_uc = int'(bp_b.update_cnt); g_mc = int'(bp_b.mispred_cnt);
          end
          default: begin
            g_tk = int'(bp_c.predTaken); g_pc = int'(bp_c.predPC);
            g_uc = int'(bp_c.update_cnt); g_mc = int'(bp_c.mispred_cnt);
          end
        endcase
        check("predTaken",   e.inst, g_tk, int'(e.taken));
        check("predPC",      e.inst, g_pc, e.pc);
        check("update_cnt",  e.inst, g_uc, e.uc);
        check("mispred_cnt", e.inst, g_mc, e.mc);
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    s_rst_n = 0; s_cur = 0; s_en = 0; s_pc = 0; s_tk = 0; s_tgt = 0; s_mis = 0; s_inv = 0;
    drive_ifs();

    cyc(0, 0, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0, 0);
    // Reset state and counter behaviour, then a reset clears the counters
    look(16'h0005);
    upd(16'h0005, 16'h0030, 0, 0, 0);
    upd(16'h0005, 16'h0030, 0, 0, 0);
    upd(16'h0005, 16'h0030, 0, 0, 0);
    look(16'h0005);
    cyc(0, 16'h0005, 1, 16'h0030, 1, 16'h0099, 1, 0);  // update in reset cycle is discarded
    look(16'h0005);
    look(16'h0030);
    // Allocate, hit, and same-index tag mismatch
    upd(16'h0000, 16'h0012, 1, 16'h0040, 1);
    look(16'h0012);
    look(16'h0022);
    // Hysteresis: counter 2 -> 3 -> 3, then step down
    upd(16'h0012, 16'h0012, 1, 16'h0040, 0);
    upd(16'h0012, 16'h0012, 1, 16'h0040, 0);
    upd(16'h0012, 16'h0012, 0, 16'h0000, 1);
    look(16'h0012);
    upd(16'h0012, 16'h0012, 0, 16'h0000, 1);
    look(16'h0012);
    // Legacy-mode check: counter at 0 still predicts taken on instance B
    upd(16'h0000, 16'h0057, 1, 16'h0abc, 0);
    upd(16'h0000, 16'h0057, 0, 0, 0);
    upd(16'h0000, 16'h0057, 0, 0, 0);
    upd(16'h0000, 16'h0057, 0, 0, 0);
    look(16'h0057);
    // Same-cycle lookup and update on idx 3: old target seen, new one next cycle
    upd(16'h0000, 16'h0013, 1, 16'h0100, 0);
    upd(16'h0013, 16'h0013, 1, 16'h0200, 0);
    look(16'h0013);
    // inv_all beats a coincident update
    cyc(1, 16'h0013, 1, 16'h0013, 1, 16'h0300, 1, 1);
    look(16'h0013);
    look(16'h0057);
    // Saturation on the WORD=4 instance plus the PC wrap
    for (int k = 0; k < 20; k++) upd(16'hFFFF, 16'h000F, 0, 0, 1);
    look(16'hFFFF);

    // Randomized traffic
    for (int n = 0; n < 1500; n++) begin
      bit rn, en, tk, mis, inv;
      rn  = ($urandom_range(0, 199) != 0);
      en  = ($urandom_range(0, 1) == 1);
      tk  = ($urandom_range(0, 2) != 0);
      mis = ($urandom_range(0, 3) == 0);
      inv = ($urandom_range(0, 59) == 0);
      cyc(rn, rnd_pc(), en, rnd_pc(), tk, int'($urandom_range(0, 16'hFFFF)), mis, inv);
    end

    @(negedge Clk);
    @(negedge Clk);
    total++;
    if (sb_q.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_drain got=%0d exp=0", sb_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
